// File: rtl/tbird_pkg.sv
// tbird_pkg: shared types and helpers for the sequential turn-signal blocks.
//   tbird_state_e : sequencer state encoding
//   therm()       : thermometer mask with the low `step` bits set, clipped to `lamps`
package tbird_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LEFT   = 2'd1,
        RIGHT  = 2'd2,
        HAZARD = 2'd3
    } tbird_state_e;

    // Widest lamp bank therm() can describe; callers truncate to their LAMPS.
    localparam int unsigned MAX_LAMPS = 32;

    function automatic logic [MAX_LAMPS-1:0] therm(input int unsigned step,
                                                   input int unsigned lamps);
        logic [MAX_LAMPS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_LAMPS; i++) begin
            if ((i < step) && (i < lamps)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/tbird_tick_gen.sv
// tbird_tick_gen: free-running step prescaler.
//   Counts 0..TICK_DIV-1 and raises tick while the count sits at TICK_DIV-1,
//   so tick is high every clk when TICK_DIV=1.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset, clears the count
//   tick    : one-cycle step enable
module tbird_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/tbird_seq_signal.sv
// tbird_seq_signal: parametrised sequential turn-signal controller.
//   Sweeps LAMPS lamps per side inner-to-outer (bit 0 innermost), with a
//   hazard mode and a prescaled step rate. All outputs are registered.
// Ports:
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   left_sw     : left turn request (level)
//   right_sw    : right turn request (level)
//   hazard_sw   : hazard request (level)
//   brake_sw    : brake request (level), present only with BRAKE_EN
//   left_lamps  : left lamp drive
//   right_lamps : right lamp drive
//   active      : high whenever the sequencer is not IDLE
// Build option:
//   BRAKE_EN : adds brake_sw and a per-clk brake overlay on the non-sweeping side(s)
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | all sequence lamps off, waiting for a request
// LEFT   | left sweep, step = number of lit left lamps
// RIGHT  | right sweep, step = number of lit right lamps
// HAZARD | both sides fully lit for one tick
module tbird_seq_signal
    import tbird_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             left_sw,
    input  logic             right_sw,
    input  logic             hazard_sw,
`ifdef BRAKE_EN
    input  logic             brake_sw,
`endif
    output logic [LAMPS-1:0] left_lamps,
    output logic [LAMPS-1:0] right_lamps,
    output logic             active
);

    localparam int SW = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);

    logic             w_tick;
    logic             w_haz;
    tbird_state_e     r_state;
    tbird_state_e     w_state_nxt;
    logic [SW-1:0]    r_step;
    logic [SW-1:0]    w_step_nxt;
    logic [LAMPS-1:0] w_sweep;
    logic [LAMPS-1:0] w_left_nxt;
    logic [LAMPS-1:0] w_right_nxt;
    logic             w_active_nxt;
    logic [LAMPS-1:0] r_left_seq;
    logic [LAMPS-1:0] r_right_seq;
    logic             r_active;

    tbird_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    // Both turn switches together are treated as a hazard request.
    assign w_haz = hazard_sw | (left_sw & right_sw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_step  <= '0;
        end else if (w_tick) begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        unique case (r_state)
            IDLE: begin
                w_step_nxt = '0;
                if (w_haz) begin
                    w_state_nxt = HAZARD;
                end else if (left_sw) begin
                    w_state_nxt = LEFT;
                    w_step_nxt  = SW'(1);
                end else if (right_sw) begin
                    w_state_nxt = RIGHT;
                    w_step_nxt  = SW'(1);
                end
            end
            LEFT, RIGHT: begin
                // The sweep ignores switch release and direction changes;
                // only a hazard request can cut it short.
                if (w_haz) begin
                    w_state_nxt = HAZARD;
                    w_step_nxt  = '0;
                end else if (r_step < STEP_MAX) begin
                    w_step_nxt = r_step + SW'(1);
                end else begin
                    w_state_nxt = IDLE;
                    w_step_nxt  = '0;
                end
            end
            HAZARD: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_step_nxt  = '0;
            end
        endcase
    end

    // Lamp patterns are decoded from the next state so the registered
    // outputs change on the same edge as the state.
    assign w_sweep = LAMPS'(therm(32'(w_step_nxt), LAMPS));

    always_comb begin
        w_left_nxt   = '0;
        w_right_nxt  = '0;
        w_active_nxt = (w_state_nxt != IDLE);
        unique case (w_state_nxt)
            LEFT:    w_left_nxt  = w_sweep;
            RIGHT:   w_right_nxt = w_sweep;
            HAZARD: begin
                w_left_nxt  = '1;
                w_right_nxt = '1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_left_seq  <= '0;
            r_right_seq <= '0;
            r_active    <= 1'b0;
        end else if (w_tick) begin
            r_left_seq  <= w_left_nxt;
            r_right_seq <= w_right_nxt;
            r_active    <= w_active_nxt;
        end
    end

    assign active = r_active;

`ifdef BRAKE_EN
    tbird_state_e w_state_eff;
    logic         w_brake_l_nxt;
    logic         w_brake_r_nxt;
    logic         r_brake_l;
    logic         r_brake_r;

    // Judge the sweeping side against the state that will hold after this
    // edge, so the overlay and sequence lamps switch together. An IDLE gap
    // with a turn switch still held counts as that side sweeping, keeping
    // the off step of a repeating sweep visible under braking.
    assign w_state_eff = w_tick ? w_state_nxt : r_state;

    assign w_brake_l_nxt = brake_sw && !w_haz && (w_state_eff != HAZARD)
                         && (w_state_eff != LEFT)
                         && !((w_state_eff == IDLE) && left_sw);
    assign w_brake_r_nxt = brake_sw && !w_haz && (w_state_eff != HAZARD)
                         && (w_state_eff != RIGHT)
                         && !((w_state_eff == IDLE) && right_sw);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_brake_l <= 1'b0;
            r_brake_r <= 1'b0;
        end else begin
            r_brake_l <= w_brake_l_nxt;
            r_brake_r <= w_brake_r_nxt;
        end
    end

    assign left_lamps  = r_left_seq  | {LAMPS{r_brake_l}};
    assign right_lamps = r_right_seq | {LAMPS{r_brake_r}};
`else
    assign left_lamps  = r_left_seq;
    assign right_lamps = r_right_seq;
`endif

endmodule

// File: tb/tb_tbird_seq_signal.sv
module tb_tbird_seq_signal;

    logic       clk;
    logic       reset_n;
    logic       left_sw, right_sw, hazard_sw;
    logic [2:0] l1, r1;
    logic       a1;
    logic       left2, right2, haz2;
    logic [4:0] l2, r2;
    logic       a2;

    int n_checks;
    int n_errors;

    tbird_seq_signal #(.LAMPS(3), .TICK_DIV(1)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .left_sw     (left_sw),
        .right_sw    (right_sw),
        .hazard_sw   (hazard_sw),
        .left_lamps  (l1),
        .right_lamps (r1),
        .active      (a1)
    );

    tbird_seq_signal #(.LAMPS(5), .TICK_DIV(4)) u_dut_pre (
        .clk         (clk),
        .reset_n     (reset_n),
        .left_sw     (left2),
        .right_sw    (right2),
        .hazard_sw   (haz2),
        .left_lamps  (l2),
        .right_lamps (r2),
        .active      (a2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic stp();
        @(posedge clk);
        #1;
    endtask

    // Advance one clk and check the small DUT's outputs.
    task automatic exp1(input string tag, input logic [2:0] l, input logic [2:0] r, input logic a);
        stp();
        chk({tag, ".l"}, 32'(l1), 32'(l));
        chk({tag, ".r"}, 32'(r1), 32'(r));
        chk({tag, ".a"}, 32'(a1), 32'(a));
    endtask

    logic [2:0] sweep3 [4];
    logic [4:0] pre5   [8];

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        sweep3    = '{3'b001, 3'b011, 3'b111, 3'b000};
        pre5      = '{5'b00000, 5'b00001, 5'b00011, 5'b00111,
                      5'b01111, 5'b11111, 5'b00000, 5'b00001};
        reset_n   = 1'b1;
        left_sw   = 1'b0;
        right_sw  = 1'b0;
        hazard_sw = 1'b0;
        left2     = 1'b0;
        right2    = 1'b0;
        haz2      = 1'b0;

        #3 reset_n = 1'b0;
        #4;
        chk("rst.l", 32'(l1), 32'h0);
        chk("rst.r", 32'(r1), 32'h0);
        chk("rst.a", 32'(a1), 32'h0);
        chk("rst.l2", 32'(l2), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) exp1($sformatf("idle%0d", i), 3'b000, 3'b000, 1'b0);

        // Held left: sweep repeats with one off step.
        left_sw = 1'b1;
        exp1("lh0", 3'b001, 3'b000, 1'b1);
        exp1("lh1", 3'b011, 3'b000, 1'b1);
        exp1("lh2", 3'b111, 3'b000, 1'b1);
        exp1("lh3", 3'b000, 3'b000, 1'b0);
        exp1("lh4", 3'b001, 3'b000, 1'b1);
        left_sw = 1'b0;
        exp1("lh5", 3'b011, 3'b000, 1'b1);
        exp1("lh6", 3'b111, 3'b000, 1'b1);
        exp1("lh7", 3'b000, 3'b000, 1'b0);
        exp1("lh8", 3'b000, 3'b000, 1'b0);

        // One-cycle pulse still completes the sweep.
        left_sw = 1'b1;
        exp1("lp0", 3'b001, 3'b000, 1'b1);
        left_sw = 1'b0;
        exp1("lp1", 3'b011, 3'b000, 1'b1);
        exp1("lp2", 3'b111, 3'b000, 1'b1);
        exp1("lp3", 3'b000, 3'b000, 1'b0);
        exp1("lp4", 3'b000, 3'b000, 1'b0);
        exp1("lp5", 3'b000, 3'b000, 1'b0);

        // Both turn switches act as hazard.
        left_sw  = 1'b1;
        right_sw = 1'b1;
        exp1("hz0", 3'b111, 3'b111, 1'b1);
        exp1("hz1", 3'b000, 3'b000, 1'b0);
        exp1("hz2", 3'b111, 3'b111, 1'b1);
        exp1("hz3", 3'b000, 3'b000, 1'b0);
        left_sw  = 1'b0;
        right_sw = 1'b0;
        exp1("hz4", 3'b000, 3'b000, 1'b0);

        // Right sweep, direction change ignored, hazard aborts at step 2.
        right_sw = 1'b1;
        exp1("rs0", 3'b000, 3'b001, 1'b1);
        right_sw = 1'b0;
        left_sw  = 1'b1;
        exp1("rs1", 3'b000, 3'b011, 1'b1);
        left_sw   = 1'b0;
        hazard_sw = 1'b1;
        exp1("rs2", 3'b111, 3'b111, 1'b1);
        hazard_sw = 1'b0;
        exp1("rs3", 3'b000, 3'b000, 1'b0);
        exp1("rs4", 3'b000, 3'b000, 1'b0);

        // Asynchronous reset in the middle of a sweep.
        left_sw = 1'b1;
        exp1("mr0", 3'b001, 3'b000, 1'b1);
        exp1("mr1", 3'b011, 3'b000, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("mr.l", 32'(l1), 32'h0);
        chk("mr.r", 32'(r1), 32'h0);
        chk("mr.a", 32'(a1), 32'h0);
        left_sw = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        left_sw = 1'b1;
        left2   = 1'b1;

        // Both DUTs restart from a cleared prescaler; the TICK_DIV=4 one
        // first steps on the fourth edge after release.
        for (int k = 1; k <= 28; k++) begin
            stp();
            chk($sformatf("ps1.l%0d", k), 32'(l1), 32'(sweep3[(k-1)%4]));
            chk($sformatf("ps2.l%0d", k), 32'(l2), 32'(pre5[k/4]));
            chk($sformatf("ps2.r%0d", k), 32'(r2), 32'h0);
            chk($sformatf("ps2.a%0d", k), 32'(a2), 32'((k/4 >= 1) && (k/4 <= 5) || (k/4 == 7)));
        end
        left_sw = 1'b0;
        left2   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
